inst_fetch_unit: RTL

- Fetch-side master for the combinational 64-bit instruction ROM: owns the fetch PC, drives ROM chip-enable/address, captures returned words.
- Buffers fetched instructions in a small prefetch queue; presents them to decode over a valid/ready handshake.
- Handles branch redirect and pipeline flush. Sits between the instruction ROM and the IF/ID stage.

---
 rtl/inst_fetch_unit.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: fetch-side master for a combinational instruction ROM.
// It owns the fetch PC and drives the ROM enable and address. Returned words
// go into a small prefetch queue. The queue head is offered to decode over a
// valid/ready handshake. A redirect or a flush empties the queue.
// Optional build macro IF_MISALIGN_EXC_EN: a misaligned redirect target halts
// fetch and raises if_misalign_o instead of being silently aligned.
module inst_fetch_unit #(
    parameter int                 ADDR_W   = 32,
    parameter int                 INST_W   = 64,
    parameter int                 QDEPTH   = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    output logic              rom_ce_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [INST_W-1:0] rom_inst_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    input  logic              flush_i,
    input  logic              id_ready_i,
    output logic              id_valid_o,
    output logic [ADDR_W-1:0] id_pc_o,
    output logic [INST_W-1:0] id_inst_o,
    output logic              if_busy_o
`ifdef IF_MISALIGN_EXC_EN
    ,
    output logic              if_misalign_o,
    output logic [ADDR_W-1:0] if_bad_pc_o
`endif
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QDEPTH);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-3){1'b1}}, 3'b000};

    logic [ADDR_W-1:0] fetch_pc_r;
    logic              ce_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic [ADDR_W-1:0] q_pc_r   [QDEPTH];
    logic [INST_W-1:0] q_inst_r [QDEPTH];
    logic              misalign_r;
    logic [ADDR_W-1:0] bad_pc_r;

    logic              clear_s;
    logic              fetch_en_s;
    logic              pop_s;
    logic              push_s;
    logic              bad_target_s;
    logic [ADDR_W-1:0] target_pc_s;

    // Handshake and fetch qualification for this cycle
    always_comb begin
        clear_s      = 1'b0;
        fetch_en_s   = 1'b0;
        pop_s        = 1'b0;
        push_s       = 1'b0;
        bad_target_s = 1'b0;
        target_pc_s  = redirect_pc_i & ALIGN_MASK;

        clear_s = redirect_i | flush_i;
`ifdef IF_MISALIGN_EXC_EN
        if (redirect_i && (redirect_pc_i[2:0] != 3'b000)) begin
            bad_target_s = 1'b1;
        end else begin
            bad_target_s = 1'b0;
        end
`endif
        // A halted unit keeps ce_r set but stops issuing ROM reads.
        fetch_en_s = ce_r & ~misalign_r;

        if ((count_r != {CNT_W{1'b0}}) && id_ready_i && !clear_s) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end

        // A full queue may still accept a word when the head leaves this cycle.
        if (fetch_en_s && ((count_r != FULL_CNT) || pop_s) && !clear_s) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end
    end

    // Fetch PC, ROM enable and misalignment state
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_r <= RESET_PC;
            ce_r       <= 1'b0;
            misalign_r <= 1'b0;
            bad_pc_r   <= {ADDR_W{1'b0}};
        end else begin
            ce_r <= 1'b1;
            if (redirect_i) begin
                if (bad_target_s) begin
                    misalign_r <= 1'b1;
                    bad_pc_r   <= redirect_pc_i;
                end else begin
                    misalign_r <= 1'b0;
                    fetch_pc_r <= target_pc_s;
                end
            end else if (push_s) begin
                fetch_pc_r <= fetch_pc_r + ADDR_W'(8);
            end
        end
    end

    // Queue pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (clear_s) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Queue storage; contents are only observed through a valid head
    always_ff @(posedge clk) begin
        if (push_s) begin
            q_pc_r[wr_ptr_r]   <= fetch_pc_r;
            q_inst_r[wr_ptr_r] <= rom_inst_i;
        end
    end

    // Output decode from the registered state
    always_comb begin
        rom_ce_o   = fetch_en_s;
        rom_addr_o = {ADDR_W{1'b0}};
        id_valid_o = 1'b0;
        id_pc_o    = {ADDR_W{1'b0}};
        id_inst_o  = {INST_W{1'b0}};
        if_busy_o  = (count_r == FULL_CNT);

        if (fetch_en_s) begin
            rom_addr_o = fetch_pc_r;
        end else begin
            rom_addr_o = {ADDR_W{1'b0}};
        end

        if (count_r != {CNT_W{1'b0}}) begin
            id_valid_o = 1'b1;
            id_pc_o    = q_pc_r[rd_ptr_r];
            id_inst_o  = q_inst_r[rd_ptr_r];
        end else begin
            id_valid_o = 1'b0;
        end
    end

`ifdef IF_MISALIGN_EXC_EN
    assign if_misalign_o = misalign_r;
    assign if_bad_pc_o   = bad_pc_r;
`endif

endmodule
